// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift/compare plus iterative radix-2 MUL/DIV/REM.
// Latency 1 cycle (WIDTH+1 for MUL/DIV*/REM*); result is held until out_ready, flush drops it.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_ctrl,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [3:0] OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_ADD  = 4'd2,  OP_SUB  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4,  OP_SLT  = 4'd5,  OP_SLTU = 4'd6,  OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8,  OP_SRA  = 4'd9,  OP_MUL  = 4'd10, OP_DIV  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12, OP_REM  = 4'd13, OP_REMU = 4'd14;
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH-1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nx;

    logic             accept, is_iter, is_div, is_sdiv, is_rem;
    logic             div_zero, div_ovf, go_busy;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] quick_res, abs_1, abs_2;

    logic [3:0]       op_r;
    logic [TAG_W-1:0] tag_r;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] a_r, b_r, p_r, a_nx, b_nx, p_nx, iter_res;
    logic [WIDTH:0]   rem_sh, diff;
    logic [SHW-1:0]   cnt;

    assign accept   = in_valid & in_ready;
    assign is_iter  = (in_ctrl >= OP_MUL) && (in_ctrl <= OP_REMU);
    assign is_div   = (in_ctrl >= OP_DIV) && (in_ctrl <= OP_REMU);
    assign is_sdiv  = (in_ctrl == OP_DIV) || (in_ctrl == OP_REM);
    assign is_rem   = (in_ctrl == OP_REM) || (in_ctrl == OP_REMU);
    assign div_zero = (in_2 == '0);
    assign div_ovf  = is_sdiv && (in_1 == MIN_VAL) && (in_2 == '1);
    // Divide-by-zero and MIN/-1 resolve immediately instead of iterating.
    assign go_busy  = is_iter && !(is_div && (div_zero || div_ovf));
    assign shamt    = in_2[SHW-1:0];
    assign abs_1    = (is_sdiv && in_1[WIDTH-1]) ? -in_1 : in_1;
    assign abs_2    = (is_sdiv && in_2[WIDTH-1]) ? -in_2 : in_2;

    always_comb begin
        quick_res = '0;
        case (in_ctrl)
            OP_AND:  quick_res = in_1 & in_2;
            OP_OR:   quick_res = in_1 | in_2;
            OP_ADD:  quick_res = in_1 + in_2;
            OP_SUB:  quick_res = in_1 - in_2;
            OP_XOR:  quick_res = in_1 ^ in_2;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, $signed(in_1) < $signed(in_2)};
            OP_SLTU: quick_res = {{(WIDTH-1){1'b0}}, in_1 < in_2};
            OP_SLL:  quick_res = in_1 << shamt;
            OP_SRL:  quick_res = in_1 >> shamt;
            OP_SRA:  quick_res = $signed(in_1) >>> shamt;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (div_zero) quick_res = is_rem ? in_1 : '1;
                else          quick_res = is_rem ? '0 : MIN_VAL;
            end
            default: quick_res = '0;
        endcase
    end

    // One iteration: shift-add multiply or restoring divide (quotient shifts into a_r).
    always_comb begin
        rem_sh = {p_r, a_r[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_r};
        if (op_r == OP_MUL) begin
            p_nx = a_r[0] ? p_r + b_r : p_r;
            a_nx = a_r >> 1;
            b_nx = b_r << 1;
        end else begin
            p_nx = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            a_nx = {a_r[WIDTH-2:0], ~diff[WIDTH]};
            b_nx = b_r;
        end
        case (op_r)
            OP_MUL:          iter_res = p_nx;
            OP_DIV, OP_DIVU: iter_res = neg_q ? -a_nx : a_nx;
            default:         iter_res = neg_r ? -p_nx : p_nx;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = go_busy ? BUSY : DONE;
            BUSY: begin
                if (flush)                 state_nx = IDLE;
                else if (cnt == CNT_LAST)  state_nx = DONE;
            end
            DONE: begin
                if (flush)          state_nx = IDLE;
                else if (accept)    state_nx = go_busy ? BUSY : DONE;
                else if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && !flush && ((state == IDLE) || ((state == DONE) && out_ready));
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= '0;
            tag_r    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            p_r      <= '0;
            cnt      <= '0;
            out      <= '0;
            out_zero <= 1'b1;
            out_tag  <= '0;
        end else if (accept) begin
            op_r  <= in_ctrl;
            tag_r <= in_tag;
            neg_q <= is_sdiv && (in_1[WIDTH-1] ^ in_2[WIDTH-1]);
            neg_r <= is_sdiv && in_1[WIDTH-1];
            cnt   <= '0;
            p_r   <= '0;
            if (in_ctrl == OP_MUL) begin
                a_r <= in_2;
                b_r <= in_1;
            end else begin
                a_r <= abs_1;
                b_r <= abs_2;
            end
            if (!go_busy) begin
                out      <= quick_res;
                out_zero <= (quick_res == '0);
                out_tag  <= in_tag;
            end
        end else if ((state == BUSY) && !flush) begin
            a_r <= a_nx;
            b_r <= b_nx;
            p_r <= p_nx;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                out      <= iter_res;
                out_zero <= (iter_res == '0);
                out_tag  <= tag_r;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table through a scoreboard, plus reset, backpressure and flush sequences.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [3:0]  in_ctrl;
    logic [31:0] in_1, in_2, out;
    logic [4:0]  in_tag, out_tag;

    alu_seq #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_1(in_1), .in_2(in_2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_zero(out_zero), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  t;
        logic [31:0] e;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    exp_t q[$];
    vec_t vt[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   seen     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] t, input logic [31:0] e, input int lat);
        vec_t v;
        v.c = c; v.a = a; v.b = b; v.t = t; v.e = e; v.lat = lat;
        return v;
    endfunction

    // Scoreboard: first appearance of a result is checked for latency, the handshake for data.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'(0));
            end else begin
                if (!seen) begin
                    check("latency", 64'(cyc), 64'(q[0].cyc));
                    seen = 1'b1;
                end
                if (out_ready) begin
                    exp_t e;
                    e = q.pop_front();
                    check("result", 64'(out), 64'(e.res));
                    check("zero_flag", 64'(out_zero), 64'(e.res == 32'd0));
                    check("tag", 64'(out_tag), 64'(e.tag));
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input logic [31:0] e, input int lat,
                        input bit push, input bit ordy, output int waited);
        @(negedge clk);
        #1;
        out_ready = ordy;
        in_valid  = 1'b1;
        in_ctrl   = c;
        in_1      = a;
        in_2      = b;
        in_tag    = t;
        #1;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #2;
            waited++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'(1));
        else if (push) q.push_back('{e, t, cyc + lat});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_timeout", 64'(q.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, bad;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ctrl = '0; in_1 = '0; in_2 = '0; in_tag = '0;

        vt.push_back(mk(4'd2,  32'hFFFF_FFFF, 32'h1,         5'h01, 32'h0,         1));
        vt.push_back(mk(4'd3,  32'd5,         32'd7,         5'h02, 32'hFFFF_FFFE, 1));
        vt.push_back(mk(4'd4,  32'hA5A5,      32'hFFFF,      5'h03, 32'h5A5A,      1));
        vt.push_back(mk(4'd9,  32'h8000_0000, 32'h24,        5'h04, 32'hF800_0000, 1));
        vt.push_back(mk(4'd7,  32'h1,         32'h3F,        5'h05, 32'h8000_0000, 1));
        vt.push_back(mk(4'd8,  32'h8000_0000, 32'h4,         5'h06, 32'h0800_0000, 1));
        vt.push_back(mk(4'd5,  32'hFFFF_FFFF, 32'h1,         5'h07, 32'h1,         1));
        vt.push_back(mk(4'd6,  32'hFFFF_FFFF, 32'h1,         5'h08, 32'h0,         1));
        vt.push_back(mk(4'd10, 32'hFFFF,      32'hFFFF,      5'h09, 32'hFFFE_0001, 33));
        vt.push_back(mk(4'd10, 32'hFFFF_FFFD, 32'd5,         5'h0A, 32'hFFFF_FFF1, 33));
        vt.push_back(mk(4'd11, 32'hFFFF_FFF9, 32'd2,         5'h0B, 32'hFFFF_FFFD, 33));
        vt.push_back(mk(4'd13, 32'hFFFF_FFF9, 32'd2,         5'h0C, 32'hFFFF_FFFF, 33));
        vt.push_back(mk(4'd12, 32'd100,       32'd7,         5'h1A, 32'd14,        33));
        vt.push_back(mk(4'd14, 32'd100,       32'd7,         5'h0D, 32'd2,         33));
        vt.push_back(mk(4'd11, 32'd7,         32'hFFFF_FFFE, 5'h0E, 32'hFFFF_FFFD, 33));
        vt.push_back(mk(4'd13, 32'd7,         32'hFFFF_FFFE, 5'h0F, 32'd1,         33));
        vt.push_back(mk(4'd12, 32'd5,         32'd0,         5'h10, 32'hFFFF_FFFF, 1));
        vt.push_back(mk(4'd13, 32'd5,         32'd0,         5'h11, 32'd5,         1));
        vt.push_back(mk(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 5'h12, 32'h8000_0000, 1));
        vt.push_back(mk(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 5'h13, 32'd0,         1));
        vt.push_back(mk(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 5'h14, 32'd0,         33));
        vt.push_back(mk(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'h15, 32'h8000_0000, 33));
        vt.push_back(mk(4'd15, 32'h1234,      32'h5678,      5'h16, 32'd0,         1));
        vt.push_back(mk(4'd0,  32'hFF00_FF00, 32'h0FF0_0FF0, 5'h17, 32'h0F00_0F00, 1));

        // Reset values.
        repeat (2) @(negedge clk);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out", 64'(out), 64'(0));
        check("rst_out_zero", 64'(out_zero), 64'(1));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;

        send(4'd1, 32'h05, 32'h30, 5'h03, 32'h35, 1, 1'b1, 1'b1, w);
        drain();

        // Asynchronous reset in the middle of a multiply.
        send(4'd10, 32'd7, 32'd9, 5'h1F, 32'd63, 33, 1'b0, 1'b1, w);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midbusy_rst_valid", 64'(out_valid), 64'(0));
        check("midbusy_rst_out", 64'(out), 64'(0));
        check("midbusy_rst_tag", 64'(out_tag), 64'(0));
        check("midbusy_rst_zero", 64'(out_zero), 64'(1));
        check("midbusy_rst_ready", 64'(in_ready), 64'(0));
        q.delete();
        seen = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Vector table, issued back to back with out_ready high.
        foreach (vt[i]) begin
            send(vt[i].c, vt[i].a, vt[i].b, vt[i].t, vt[i].e, vt[i].lat, 1'b1, 1'b1, w);
            if (i > 0 && vt[i-1].lat == 1) check("back_to_back_wait", 64'(w), 64'(0));
        end
        drain();

        // Backpressure: result held stable, no new op accepted.
        send(4'd4, 32'h1234, 32'hFF00, 5'h07, 32'hED34, 1, 1'b1, 1'b0, w);
        repeat (5) begin
            @(negedge clk);
            #2;
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_out", 64'(out), 64'(32'hED34));
            check("bp_tag", 64'(out_tag), 64'(5'h07));
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        send(4'd1, 32'h0F, 32'hF0, 5'h09, 32'hFF, 1, 1'b1, 1'b1, w);
        check("bp_same_cycle_accept", 64'(w), 64'(0));
        drain();

        // Flush at BUSY count 10 while an op is also offered.
        send(4'd12, 32'd1000, 32'd3, 5'h0B, 32'd333, 33, 1'b0, 1'b1, w);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 4'd2; in_1 = 32'd1; in_2 = 32'd2; in_tag = 5'h02;
        #1 check("flush_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            #2;
            if (out_valid) bad++;
        end
        check("flush_no_result", 64'(bad), 64'(0));
        check("flush_out_hold", 64'(out), 64'(32'hFF));
        check("flush_tag_hold", 64'(out_tag), 64'(5'h09));
        send(4'd0, 32'hF0, 32'h3C, 5'h0C, 32'h30, 1, 1'b1, 1'b1, w);
        drain();

        // Flush in IDLE together with a valid op: nothing accepted.
        @(negedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 4'd2; in_1 = 32'd1; in_2 = 32'd1; in_tag = 5'h04;
        #1 check("idle_flush_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        #2;
        check("idle_flush_valid", 64'(out_valid), 64'(0));
        check("idle_flush_out", 64'(out), 64'(32'h30));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
